// File: rtl/opti_pkg.sv
// opti_pkg: shared state encoding, default widths and a constant clog2 helper for the stream controller.
// Contents: opti_state_t (IDLE, WAIT_IN, SETTLE, STREAM, DONE), DEF_* parameter defaults, clog2().
package opti_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_IN,
        SETTLE,
        STREAM,
        DONE
    } opti_state_t;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_ADDR_W         = 11;
    localparam int DEF_NUM_SAMPLES    = 2048;
    localparam int DEF_SETTLE_SAMPLES = 238;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

endpackage

// File: rtl/opti_out_reg.sv
// opti_out_reg: one-deep valid/ready output register with load, hold and sticky overrun flag.
// Ports: clk, rst (sync, active-high); en (streaming allowed); clr (drop held sample, zero outputs);
//        ovr_clr (clear overrun); in_valid/in_data/in_addr (candidate sample); out_ready (consumer);
//        load (sample accepted this cycle); data_out/addr/valid (presented sample); overrun (sticky drop flag).
module opti_out_reg #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              ovr_clr,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic              out_ready,
    output logic              load,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr,
    output logic              valid,
    output logic              overrun
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              valid_q, valid_d;
    logic              ovr_q, ovr_d;

    assign load = en && in_valid && (!valid_q || out_ready);

    always_comb begin
        data_d  = clr ? '0 : load ? in_data : data_q;
        addr_d  = clr ? '0 : load ? in_addr : addr_q;
        valid_d = clr ? 1'b0 : load ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
        // A sample arriving while the held one is stalled is lost; the address is not consumed.
        ovr_d   = ovr_clr ? 1'b0 : ovr_q | (!clr && en && in_valid && valid_q && !out_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out = data_q;
    assign addr     = addr_q;
    assign valid    = valid_q;
    assign overrun  = ovr_q;

endmodule

// File: rtl/opti_stream_ctrl.sv
// opti_stream_ctrl: IIR output controller - enables the pipeline, discards settling outputs, streams samples.
// Ports: clk, rst (sync, active-high); start, abort; data_in_valid; sos_out_valid/sos_out_data (last SOS stage);
//        out_ready; pipeline_en; data_out/addr/data_out_valid (ready/valid stream); stable_out; filter_done;
//        overrun (sticky); peak_abs (only with OPTI_PEAK_DETECT_EN defined: saturated max |sample| this run).
module opti_stream_ctrl
    import opti_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int NUM_SAMPLES    = DEF_NUM_SAMPLES,
    parameter int SETTLE_SAMPLES = DEF_SETTLE_SAMPLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              data_in_valid,
    input  logic              sos_out_valid,
    input  logic [DATA_W-1:0] sos_out_data,
    input  logic              out_ready,
    output logic              pipeline_en,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] addr,
    output logic              data_out_valid,
    output logic              stable_out,
    output logic              filter_done,
`ifdef OPTI_PEAK_DETECT_EN
    output logic [DATA_W-1:0] peak_abs,
`endif
    output logic              overrun
);

    localparam int SW = clog2(SETTLE_SAMPLES + 1);
    localparam int LW = ADDR_W + 1;

    opti_state_t       state_q, state_d;
    logic [SW-1:0]     settle_cnt_q, settle_cnt_d;
    logic [LW-1:0]     load_cnt_q, load_cnt_d;
    logic              stable_q, stable_d;
    logic              load, start_ok, abort_hit, room;

    assign abort_hit = abort && state_q != IDLE;
    assign start_ok  = start && !abort && (state_q == IDLE || state_q == DONE);
    assign room      = load_cnt_q < LW'(NUM_SAMPLES);

    opti_out_reg #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .en        (state_q == STREAM),
        .clr       (start_ok || abort_hit),
        .ovr_clr   (start_ok),
        .in_valid  (sos_out_valid && room),
        .in_data   (sos_out_data),
        .in_addr   (load_cnt_q[ADDR_W-1:0]),
        .out_ready (out_ready),
        .load      (load),
        .data_out  (data_out),
        .addr      (addr),
        .valid     (data_out_valid),
        .overrun   (overrun)
    );

    always_comb begin
        state_d = state_q;
        if (abort_hit)
            state_d = IDLE;
        else
            case (state_q)
                IDLE, DONE: if (start_ok) state_d = WAIT_IN;
                WAIT_IN:    if (data_in_valid) state_d = (SETTLE_SAMPLES == 0) ? STREAM : SETTLE;
                SETTLE:     if (sos_out_valid && settle_cnt_q == SW'(SETTLE_SAMPLES - 1)) state_d = STREAM;
                // Quota exhausted and the last sample handed over.
                STREAM:     if (!room && data_out_valid && out_ready) state_d = DONE;
                default:    state_d = IDLE;
            endcase
        settle_cnt_d = start_ok ? '0 : settle_cnt_q + SW'(state_q == SETTLE && sos_out_valid);
        load_cnt_d   = start_ok ? '0 : load_cnt_q + LW'(load);
        stable_d     = (start_ok || abort_hit || state_d == DONE) ? 1'b0 : stable_q | load;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            load_cnt_q   <= '0;
            stable_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            load_cnt_q   <= load_cnt_d;
            stable_q     <= stable_d;
        end
    end

    assign pipeline_en = state_q == WAIT_IN || state_q == SETTLE || state_q == STREAM;
    assign filter_done = state_q == DONE;
    assign stable_out  = stable_q;

`ifdef OPTI_PEAK_DETECT_EN
    logic [DATA_W-1:0] peak_q, peak_d, mag;

    always_comb begin
        // The most negative code has no positive twin; clamp it to the largest positive value.
        mag    = !sos_out_data[DATA_W-1] ? sos_out_data :
                 (sos_out_data == {1'b1, {(DATA_W-1){1'b0}}}) ? {1'b0, {(DATA_W-1){1'b1}}} : -sos_out_data;
        peak_d = start_ok ? '0 : (load && mag > peak_q) ? mag : peak_q;
    end

    always_ff @(posedge clk) begin
        if (rst) peak_q <= '0;
        else     peak_q <= peak_d;
    end

    assign peak_abs = peak_q;
`endif

endmodule

// File: doc/opti_stream_ctrl.md
Name: opti_stream_ctrl

Overview:
Parametrised next-generation output controller for the cascaded-SOS IIR filter.
- Enables the filter pipeline and waits for the first input sample.
- Discards a configurable number of settling outputs, then streams a configurable number of filtered samples to a ready/valid consumer with sample index.
- Adds backpressure, overrun detection and abort.
- Sits between the last SOS stage and the result RAM / output port.

Parameters:
- DATA_W, 16, sample width (two's complement)
- ADDR_W, 11, sample index width
- NUM_SAMPLES, 2048, samples streamed per run (≤ 2**ADDR_W)
- SETTLE_SAMPLES, 238, initial SOS outputs discarded (≥ 0)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; honoured only in IDLE or DONE
- abort  in  1  terminate the run immediately
- data_in_valid  in  1  filter input sample strobe
- sos_out_valid  in  1  last-stage output strobe
- sos_out_data  in  DATA_W  last-stage output sample
- out_ready  in  1  consumer accepts data_out
- pipeline_en  out  1  filter pipeline enable
- data_out  out  DATA_W  presented sample
- addr  out  ADDR_W  index of presented sample
- data_out_valid  out  1  data_out/addr valid, held until accepted
- stable_out  out  1  settling finished, stays high until run ends
- filter_done  out  1  high in DONE
- overrun  out  1  sticky: a sample was dropped due to backpressure

Behaviour:
- Reset (rst=1 at edge): state=IDLE. Every output 0. Internal counters 0.
- FSM states: IDLE, WAIT_IN, SETTLE, STREAM, DONE.
  - IDLE/DONE + start → WAIT_IN. Clears counters, stable_out, filter_done and overrun. Sets pipeline_en=1. data_out_valid=0.
  - WAIT_IN: the first data_in_valid → SETTLE, or → STREAM if SETTLE_SAMPLES=0. sos_out_valid seen in WAIT_IN, including the same cycle as data_in_valid, is ignored.
  - SETTLE: each sos_out_valid increments settle_cnt. That beat is discarded. The beat that makes settle_cnt==SETTLE_SAMPLES moves the FSM to STREAM, so beat SETTLE_SAMPLES+1 is the first streamed sample.
  - STREAM: see output register below. After the handshake of the sample with addr==NUM_SAMPLES-1 → DONE next cycle.
  - DONE: pipeline_en=0. filter_done=1. stable_out=0. Holds until start.
- abort in any non-IDLE state → IDLE next cycle. pipeline_en, data_out_valid and stable_out go to 0. filter_done stays 0. overrun is retained. abort and start in the same cycle: abort wins.
- start while in WAIT_IN, SETTLE or STREAM is ignored.
- Output register (STREAM only, one-deep):
  - Loads when sos_out_valid && load_cnt<NUM_SAMPLES && (!data_out_valid || out_ready).
  - On load: data_out<=sos_out_data, addr<=load_cnt, load_cnt++, data_out_valid<=1.
  - Latency is 1 cycle from sos_out_valid to data_out_valid.
  - stable_out rises together with the first data_out_valid.
  - A handshake (data_out_valid && out_ready) with no new load clears data_out_valid.
  - data_out and addr are stable while data_out_valid && !out_ready.
- Overrun: sos_out_valid while data_out_valid && !out_ready in STREAM → sample dropped, load_cnt unchanged, overrun<=1 (sticky). addr sequence stays contiguous.
- sos_out_valid after load_cnt==NUM_SAMPLES is ignored and does not set overrun.
- Counter widths:
  - settle_cnt: clog2(SETTLE_SAMPLES+1) bits.
  - load_cnt: ADDR_W+1 bits, no wrap.

Optional Feature:
OPTI_PEAK_DETECT_EN
- Defined: adds output peak_abs [DATA_W-1:0], cleared on start. On each load, updates to max(peak_abs, |sos_out_data|). The most negative input saturates to 2**(DATA_W-1)-1. Retained through DONE and abort.
- Undefined: port and logic absent. Behaviour otherwise identical.

Decomposition:
- Package opti_pkg: FSM state enum (opti_state_t), default width localparams, and a clog2 helper.
- One sub-module, opti_out_reg: one-deep valid/ready register with load, hold and overrun-flag logic, parametrised by DATA_W and ADDR_W. The FSM and counters stay in the top module.

Test Plan:
(SETTLE_SAMPLES=4, NUM_SAMPLES=8, out_ready=1 unless stated)
- Basic run: start, one data_in_valid, then 12 sos_out_valid beats with data 0x0001..0x000C → beats 1-4 discarded; data_out 0x0005..0x000C at addr 0..7, each 1 cycle after its strobe; stable_out rises with addr 0; filter_done=1 and pipeline_en=0 the cycle after addr 7 is accepted.
- Backpressure: out_ready=0 for 3 cycles while addr 2 is held, 2 strobes arrive → data_out/addr frozen, both strobes dropped, overrun=1, next accepted sample gets addr 3.
- Abort mid-stream at addr 5, with start in the same cycle → IDLE next cycle; all outputs 0 except overrun retained; a fresh start then streams from addr 0 again.
- Pre-input and post-quota strobes: sos_out_valid in WAIT_IN and a 13th strobe after NUM_SAMPLES loads → neither is counted nor output, and overrun stays 0.
- Reset mid-SETTLE: rst=1 for 1 cycle → next cycle all outputs 0 and state IDLE; start during SETTLE without reset has no effect.
- Peak detect (macro on): samples 0x7FF0, 0x8000, 0x0010 → peak_abs=0x7FFF.
